if_stage: RTL and testbench



---
 rtl/if_stage_if.sv | 32 +++
 rtl/if_stage.sv | 166 ++++++++++++++++
 tb/tb_if_stage.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ============================================================================
// Module   : if_stage_if
// Purpose  : Instruction-memory request/acknowledge bus between fetch and imem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if #(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32
);
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_ack;
   logic [DATA_WIDTH-1:0] imem_rd_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rd_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rd_data
   );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch with PC, skid buffer and stallable/flushable
//            output register. Optional bus timeout via IF_BUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
   parameter int                    ADDR_WIDTH   = 30,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
`ifdef IF_BUS_TIMEOUT_EN
   parameter int                    TIMEOUT_CYCLES = 255,
`endif
   parameter logic [DATA_WIDTH-1:0] NOP_INSN     = '0
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  stall,
   input  wire logic                  flush,
   input  wire logic [ADDR_WIDTH-1:0] new_pc,
   input  wire logic                  br_taken,
   input  wire logic [ADDR_WIDTH-1:0] br_addr,
   if_stage_if.master                 imem,
   output logic      [ADDR_WIDTH-1:0] if_pc,
   output logic      [DATA_WIDTH-1:0] if_insn,
   output logic                       if_en,
`ifdef IF_BUS_TIMEOUT_EN
   output logic                       if_bus_err,
`endif
   output logic                       if_busy
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_DROP  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_next;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] drop_addr;
   logic [ADDR_WIDTH-1:0] buf_pc;
   logic [DATA_WIDTH-1:0] buf_insn;

   logic                  req;
   logic                  ack;
   logic                  busy;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] target;

   logic                  load_bubble;
   logic                  load_fetch;
   logic                  load_buf;
   logic                  skid_load;
   logic                  pc_advance;

   assign req      = (state != ST_FULL) & ~reset;
   assign ack      = req & imem.imem_ack;
   assign busy     = req & ~imem.imem_ack;
   assign redirect = flush | (br_taken & ~stall);
   assign target   = flush ? new_pc : br_addr;

   assign imem.imem_req  = req;
   // While dropping, the bus must keep presenting the address already in flight.
   assign imem.imem_addr = (state == ST_DROP) ? drop_addr : pc;
   assign if_busy        = busy;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (redirect) begin
         state_next = busy ? ST_DROP : ST_FETCH;
      end else begin
         case (state)
            ST_FETCH: if (ack && stall) state_next = ST_FULL;
            ST_DROP:  if (ack)          state_next = ST_FETCH;
            ST_FULL:  if (!stall)       state_next = ST_FETCH;
            default:                    state_next = ST_FETCH;
         endcase
      end
   end

   always_comb begin
      load_bubble = 1'b0;
      load_fetch  = 1'b0;
      load_buf    = 1'b0;
      skid_load   = 1'b0;
      pc_advance  = 1'b0;
      if (redirect) begin
         load_bubble = 1'b1;
      end else begin
         case (state)
            ST_FETCH: begin
               if (ack) begin
                  pc_advance = 1'b1;
                  skid_load  = stall;
                  load_fetch = ~stall;
               end else begin
                  load_bubble = ~stall;
               end
            end
            ST_DROP:  load_bubble = ~stall;
            ST_FULL:  load_buf    = ~stall;
            default:  load_bubble = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_VECTOR;
         drop_addr <= '0;
         buf_pc    <= '0;
         buf_insn  <= '0;
         if_pc     <= RESET_VECTOR;
         if_insn   <= NOP_INSN;
         if_en     <= 1'b0;
      end else begin
         if (redirect)        pc <= target;
         else if (pc_advance) pc <= pc + 1'b1;

         if (state != ST_DROP) drop_addr <= pc;

         if (skid_load) begin
            buf_pc   <= pc;
            buf_insn <= imem.imem_rd_data;
         end

         if (load_bubble) begin
            if_insn <= NOP_INSN;
            if_en   <= 1'b0;
         end else if (load_fetch) begin
            if_pc   <= pc;
            if_insn <= imem.imem_rd_data;
            if_en   <= 1'b1;
         end else if (load_buf) begin
            if_pc   <= buf_pc;
            if_insn <= buf_insn;
            if_en   <= 1'b1;
         end
      end
   end

`ifdef IF_BUS_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] busy_cnt;

   // Counter saturates so the error cannot re-arm during one long stall.
   always_ff @(posedge clk) begin
      if (reset || !busy)         busy_cnt <= 8'd0;
      else if (busy_cnt != 8'hFF) busy_cnt <= busy_cnt + 8'd1;

      if (reset || flush)                      if_bus_err <= 1'b0;
      else if (busy && busy_cnt == TIMEOUT_LAST) if_bus_err <= 1'b1;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed self-checking bench for if_stage with a programmable-wait
//            memory model returning 0xA0000000 | address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;
   localparam int              AW  = 30;
   localparam int              DW  = 32;
   localparam logic [DW-1:0]   NOP = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          br_taken = 1'b0;
   logic [AW-1:0] new_pc = '0;
   logic [AW-1:0] br_addr = '0;
   logic [AW-1:0] if_pc;
   logic [DW-1:0] if_insn;
   logic          if_en;
   logic          if_busy;
`ifdef IF_BUS_TIMEOUT_EN
   logic          if_bus_err;
`endif

   int checks = 0;
   int failures = 0;
   int ack_delay = 0;
   int wait_cnt = 0;

   if_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) imem ();

   assign imem.imem_ack     = imem.imem_req && (wait_cnt >= ack_delay);
   assign imem.imem_rd_data = 32'hA000_0000 | {2'b00, imem.imem_addr};

   always @(posedge clk) wait_cnt <= (imem.imem_req && !imem.imem_ack) ? wait_cnt + 1 : 0;
   always #5 clk = ~clk;

   if_stage #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .RESET_VECTOR('0),
`ifdef IF_BUS_TIMEOUT_EN
      .TIMEOUT_CYCLES(10),
`endif
      .NOP_INSN(NOP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .flush(flush),
      .new_pc(new_pc),
      .br_taken(br_taken),
      .br_addr(br_addr),
      .imem(imem),
      .if_pc(if_pc),
      .if_insn(if_insn),
      .if_en(if_en),
`ifdef IF_BUS_TIMEOUT_EN
      .if_bus_err(if_bus_err),
`endif
      .if_busy(if_busy)
   );

   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return 32'hA000_0000 | {2'b00, a};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      #1;
      checks++;
      if ({if_en, if_pc, if_insn} !== {1'b0, AW'(0), NOP}) begin
         failures++;
         $display("FAIL reset_out got en=%b pc=%0h insn=%0h exp en=0 pc=0 insn=%0h", if_en, if_pc, if_insn, NOP);
      end
      checks++;
      if ({imem.imem_req, if_busy} !== 2'b00) begin
         failures++;
         $display("FAIL reset_req got req=%b busy=%b exp 0 0", imem.imem_req, if_busy);
      end
   endtask

   task automatic test_stream();
      reset = 1'b0;
      #1;
      checks++;
      if ({imem.imem_req, imem.imem_addr} !== {1'b1, AW'(0)}) begin
         failures++;
         $display("FAIL stream_first got req=%b addr=%0h exp 1 0", imem.imem_req, imem.imem_addr);
      end
      for (int i = 1; i <= 6; i++) begin
         step();
         #1;
         checks++;
         if ({imem.imem_addr, if_pc, if_en, if_insn} !== {AW'(i), AW'(i - 1), 1'b1, word(AW'(i - 1))}) begin
            failures++;
            $display("FAIL stream_%0d got addr=%0h pc=%0h en=%b insn=%0h exp addr=%0h pc=%0h en=1",
                     i, imem.imem_addr, if_pc, if_en, if_insn, i, i - 1);
         end
      end
   endtask

   task automatic test_wait();
      ack_delay = 2;
      for (int k = 0; k < 6; k++) begin
         logic [AW-1:0] e_pc;
         logic          e_en;
         logic [DW-1:0] e_insn;
         if (k > 0) step();
         #1;
         e_pc   = AW'(5 + k / 3);
         e_en   = (k % 3 == 0);
         e_insn = e_en ? word(e_pc) : NOP;
         checks++;
         if ({imem.imem_addr, if_busy, if_pc, if_en, if_insn} !==
             {AW'(6 + k / 3), (k % 3 != 2), e_pc, e_en, e_insn}) begin
            failures++;
            $display("FAIL wait_%0d got addr=%0h busy=%b pc=%0h en=%b insn=%0h exp addr=%0h pc=%0h en=%b insn=%0h",
                     k, imem.imem_addr, if_busy, if_pc, if_en, if_insn, 6 + k / 3, e_pc, e_en, e_insn);
         end
      end
   endtask

   task automatic test_stall();
      step();
      ack_delay = 0;
      #1;
      checks++;
      if ({imem.imem_addr, if_pc, if_en} !== {AW'(8), AW'(7), 1'b1}) begin
         failures++;
         $display("FAIL stall_pre got addr=%0h pc=%0h en=%b exp 8 7 1", imem.imem_addr, if_pc, if_en);
      end
      step();
      stall = 1'b1;
      #1;
      checks++;
      if ({imem.imem_req, imem.imem_addr, if_pc, if_en} !== {1'b1, AW'(9), AW'(8), 1'b1}) begin
         failures++;
         $display("FAIL stall_ack got req=%b addr=%0h pc=%0h en=%b exp 1 9 8 1",
                  imem.imem_req, imem.imem_addr, if_pc, if_en);
      end
      for (int n = 0; n < 3; n++) begin
         step();
         #1;
         checks++;
         if ({imem.imem_req, if_busy, if_pc, if_en, if_insn} !== {2'b00, AW'(8), 1'b1, word(AW'(8))}) begin
            failures++;
            $display("FAIL stall_full_%0d got req=%b busy=%b pc=%0h en=%b exp req=0 busy=0 pc=8 en=1",
                     n, imem.imem_req, if_busy, if_pc, if_en);
         end
      end
      step();
      stall = 1'b0;
      #1;
      checks++;
      if ({imem.imem_req, if_pc} !== {1'b0, AW'(8)}) begin
         failures++;
         $display("FAIL stall_release got req=%b pc=%0h exp 0 8", imem.imem_req, if_pc);
      end
      step();
      #1;
      checks++;
      if ({imem.imem_req, imem.imem_addr, if_pc, if_en, if_insn} !== {1'b1, AW'(10), AW'(9), 1'b1, word(AW'(9))}) begin
         failures++;
         $display("FAIL stall_drain got req=%b addr=%0h pc=%0h en=%b insn=%0h exp 1 a 9 1 %0h",
                  imem.imem_req, imem.imem_addr, if_pc, if_en, if_insn, word(AW'(9)));
      end
   endtask

   task automatic test_branch();
      ack_delay = 2;
      step();
      br_taken = 1'b1;
      br_addr  = AW'(32'h40);
      #1;
      checks++;
      if ({if_busy, imem.imem_addr, if_pc, if_en, if_insn} !== {1'b1, AW'(10), AW'(9), 1'b0, NOP}) begin
         failures++;
         $display("FAIL branch_issue got busy=%b addr=%0h pc=%0h en=%b insn=%0h exp 1 a 9 0 nop",
                  if_busy, imem.imem_addr, if_pc, if_en, if_insn);
      end
      step();
      br_taken = 1'b0;
      #1;
      checks++;
      if ({imem.imem_addr, imem.imem_ack, if_en, if_insn} !== {AW'(10), 1'b1, 1'b0, NOP}) begin
         failures++;
         $display("FAIL branch_drop got addr=%0h ack=%b en=%b insn=%0h exp a 1 0 nop",
                  imem.imem_addr, imem.imem_ack, if_en, if_insn);
      end
      for (int n = 0; n < 3; n++) begin
         step();
         #1;
         checks++;
         if ({imem.imem_addr, if_en} !== {AW'(32'h40), 1'b0}) begin
            failures++;
            $display("FAIL branch_wait_%0d got addr=%0h en=%b pc=%0h exp addr=40 en=0",
                     n, imem.imem_addr, if_en, if_pc);
         end
      end
      step();
      #1;
      checks++;
      if ({imem.imem_addr, if_pc, if_en, if_insn} !== {AW'(32'h41), AW'(32'h40), 1'b1, word(AW'(32'h40))}) begin
         failures++;
         $display("FAIL branch_target got addr=%0h pc=%0h en=%b insn=%0h exp 41 40 1",
                  imem.imem_addr, if_pc, if_en, if_insn);
      end
   endtask

   task automatic test_flush();
      ack_delay = 0;
      flush     = 1'b1;
      new_pc    = AW'(32'h100);
      br_taken  = 1'b1;
      br_addr   = AW'(32'h40);
      stall     = 1'b1;
      #1;
      checks++;
      if ({imem.imem_req, imem.imem_addr, if_busy} !== {1'b1, AW'(32'h41), 1'b0}) begin
         failures++;
         $display("FAIL flush_issue got req=%b addr=%0h busy=%b exp 1 41 0", imem.imem_req, imem.imem_addr, if_busy);
      end
      step();
      flush    = 1'b0;
      br_taken = 1'b0;
      stall    = 1'b0;
      #1;
      checks++;
      if ({imem.imem_addr, if_pc, if_en, if_insn} !== {AW'(32'h100), AW'(32'h40), 1'b0, NOP}) begin
         failures++;
         $display("FAIL flush_bubble got addr=%0h pc=%0h en=%b insn=%0h exp 100 40 0 nop",
                  imem.imem_addr, if_pc, if_en, if_insn);
      end
      step();
      #1;
      checks++;
      if ({imem.imem_addr, if_pc, if_en, if_insn} !== {AW'(32'h101), AW'(32'h100), 1'b1, word(AW'(32'h100))}) begin
         failures++;
         $display("FAIL flush_target got addr=%0h pc=%0h en=%b insn=%0h exp 101 100 1",
                  imem.imem_addr, if_pc, if_en, if_insn);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      #1;
      checks++;
      if ({imem.imem_req, if_busy} !== 2'b00) begin
         failures++;
         $display("FAIL midreset_req got req=%b busy=%b exp 0 0", imem.imem_req, if_busy);
      end
      step();
      reset = 1'b0;
      #1;
      checks++;
      if ({if_pc, if_en, if_insn, imem.imem_req, imem.imem_addr} !== {AW'(0), 1'b0, NOP, 1'b1, AW'(0)}) begin
         failures++;
         $display("FAIL midreset_state got pc=%0h en=%b insn=%0h req=%b addr=%0h exp 0 0 nop 1 0",
                  if_pc, if_en, if_insn, imem.imem_req, imem.imem_addr);
      end
   endtask

`ifdef IF_BUS_TIMEOUT_EN
   task automatic test_timeout();
      ack_delay = 100000;
      for (int n = 2; n <= 10; n++) step();
      #1;
      checks++;
      if ({if_bus_err, if_busy} !== 2'b01) begin
         failures++;
         $display("FAIL timeout_pre got err=%b busy=%b exp 0 1", if_bus_err, if_busy);
      end
      step();
      #1;
      checks++;
      if ({if_bus_err, imem.imem_req, imem.imem_addr} !== {1'b1, 1'b1, AW'(0)}) begin
         failures++;
         $display("FAIL timeout_set got err=%b req=%b addr=%0h exp 1 1 0", if_bus_err, imem.imem_req, imem.imem_addr);
      end
      flush  = 1'b1;
      new_pc = '0;
      step();
      flush = 1'b0;
      #1;
      checks++;
      if (if_bus_err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_clear got err=%b exp 0", if_bus_err);
      end
      ack_delay = 0;
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_wait();
      test_stall();
      test_branch();
      test_flush();
      test_reset_mid();
`ifdef IF_BUS_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
